// File: rtl/branch_predict_resolve_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_resolve_if
// Description : Fetch lookup and Execute resolve signals of the branch
//               predictor, with pipeline (master) and predictor (slave) views.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_predict_resolve_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  PCF;
  logic             PredictTakenF;
  logic             ResolveValid_E;
  logic [2:0]       ConditionalPCSrc_E;
  logic [XLEN-1:0]  PCE;
  logic             PredictedTaken_E;
  logic             Zero;
  logic             Carry;
  logic             Negative;
  logic             oVerflow;
  logic [XLEN-1:0]  PCp4_E;
  logic [XLEN-1:0]  BranchTarget_E;
  logic             Taken_E;
  logic             Mispredict_E;
  logic [XLEN-1:0]  RedirectPC_E;
  logic [CNT_W-1:0] MispredictCount;

  modport master (
    output PCF, ResolveValid_E, ConditionalPCSrc_E, PCE, PredictedTaken_E,
           Zero, Carry, Negative, oVerflow, PCp4_E, BranchTarget_E,
    input  PredictTakenF, Taken_E, Mispredict_E, RedirectPC_E, MispredictCount
  );

  modport slave (
    input  PCF, ResolveValid_E, ConditionalPCSrc_E, PCE, PredictedTaken_E,
           Zero, Carry, Negative, oVerflow, PCp4_E, BranchTarget_E,
    output PredictTakenF, Taken_E, Mispredict_E, RedirectPC_E, MispredictCount
  );
endinterface
`default_nettype wire

// File: rtl/branch_predict_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_resolve
// Description : Execute-stage branch resolution, misprediction detection and
//               a direct-mapped table of 2-bit saturating direction counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_resolve #(
  parameter int         XLEN          = 32,
  parameter int         ENTRIES       = 64,
  parameter int         INDEX_LO      = 2,
  parameter logic [1:0] COUNTER_RESET = 2'b01,
  parameter int         CNT_W         = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  branch_predict_resolve_if.slave bus
);

  localparam int         c_IDX_W = $clog2(ENTRIES);
  localparam logic [2:0] c_NONE  = 3'd0;
  localparam logic [2:0] c_BEQ   = 3'd1;
  localparam logic [2:0] c_BNE   = 3'd2;
  localparam logic [2:0] c_BLT   = 3'd3;
  localparam logic [2:0] c_BGE   = 3'd4;
  localparam logic [2:0] c_BLTU  = 3'd5;
  localparam logic [2:0] c_BGEU  = 3'd6;

  logic [1:0]         r_table [ENTRIES];
  logic [CNT_W-1:0]   r_mispredict_count;

  logic               w_taken;
  logic               w_is_branch_code;
  logic               w_branch;
  logic               w_mispredict;
  logic [c_IDX_W-1:0] w_lookup_idx;
  logic [c_IDX_W-1:0] w_update_idx;
  logic [1:0]         w_cur_ctr;
  logic [1:0]         w_next_ctr;
  logic               w_unused_pc;

  // Signed less-than is N^V; Carry already encodes unsigned rs1<rs2.
  always_comb begin
    w_taken          = 1'b0;
    w_is_branch_code = 1'b1;
    case (bus.ConditionalPCSrc_E)
      c_BEQ:   w_taken = bus.Zero;
      c_BNE:   w_taken = ~bus.Zero;
      c_BLT:   w_taken = bus.Negative ^ bus.oVerflow;
      c_BGE:   w_taken = ~(bus.Negative ^ bus.oVerflow);
      c_BLTU:  w_taken = bus.Carry;
      c_BGEU:  w_taken = ~bus.Carry;
      c_NONE:  w_is_branch_code = 1'b0;
      default: w_is_branch_code = 1'b0;
    endcase
  end

  assign w_branch     = bus.ResolveValid_E & w_is_branch_code;
  assign w_mispredict = w_branch & (w_taken != bus.PredictedTaken_E);

  assign w_lookup_idx = bus.PCF[INDEX_LO +: c_IDX_W];
  assign w_update_idx = bus.PCE[INDEX_LO +: c_IDX_W];
  assign w_unused_pc  = ^{bus.PCF, bus.PCE};

  assign w_cur_ctr = r_table[w_update_idx];

  always_comb begin
    w_next_ctr = w_cur_ctr;
    if (w_taken) begin
      if (w_cur_ctr != 2'b11) w_next_ctr = w_cur_ctr + 2'b01;
    end else begin
      if (w_cur_ctr != 2'b00) w_next_ctr = w_cur_ctr - 2'b01;
    end
  end

  // Flop array rather than SRAM so every entry can be cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) r_table[i] <= COUNTER_RESET;
    end else if (w_branch) begin
      r_table[w_update_idx] <= w_next_ctr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mispredict_count <= '0;
    end else if (w_mispredict) begin
      r_mispredict_count <= r_mispredict_count + 1'b1;
    end
  end

  // No bypass: lookup shows the counter as it stands before this edge's update.
  assign bus.PredictTakenF   = r_table[w_lookup_idx][1];
  assign bus.Taken_E         = w_taken;
  assign bus.Mispredict_E    = w_mispredict;
  assign bus.RedirectPC_E    = w_taken ? bus.BranchTarget_E : bus.PCp4_E;
  assign bus.MispredictCount = r_mispredict_count;

  always @(posedge clk) begin
    if (!reset) assert (!(bus.ResolveValid_E && (bus.ConditionalPCSrc_E == 3'd7)));
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_resolve.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_resolve
// Description : Directed and operand-randomised bench against a counter-table
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_resolve;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [1:0]  mdl [64];
  logic [31:0] mcount;

  branch_predict_resolve_if #(.XLEN(32), .CNT_W(32)) bif ();

  branch_predict_resolve #(
    .XLEN(32), .ENTRIES(64), .INDEX_LO(2), .COUNTER_RESET(2'b01), .CNT_W(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mdl[i] = 2'd1;
    mcount = 32'd0;
  endtask

  task automatic lookup(input logic [31:0] pcf);
    bif.ResolveValid_E = 1'b0;
    bif.PCF = pcf;
    #1;
    chk("lookup_predict", bif.PredictTakenF, mdl[pcf[7:2]][1]);
  endtask

  // One resolve cycle; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic valid, input logic [2:0] code, input logic [31:0] pce,
                      input logic [31:0] pcf, input logic pred, input logic z, input logic c,
                      input logic n, input logic v, input logic exp_taken,
                      input logic [31:0] target);
    logic is_br, exp_t, exp_branch, exp_mis;
    bif.ResolveValid_E     = valid;
    bif.ConditionalPCSrc_E = code;
    bif.PCE                = pce;
    bif.PCF                = pcf;
    bif.PredictedTaken_E   = pred;
    bif.Zero = z; bif.Carry = c; bif.Negative = n; bif.oVerflow = v;
    bif.PCp4_E             = pce + 32'd4;
    bif.BranchTarget_E     = target;
    #1;
    is_br      = (code >= 3'd1) && (code <= 3'd6);
    exp_t      = is_br ? exp_taken : 1'b0;
    exp_branch = valid && is_br;
    exp_mis    = exp_branch && (exp_t != pred);
    chk("predict_f", bif.PredictTakenF, mdl[pcf[7:2]][1]);
    if (valid) begin
      chk("taken", bif.Taken_E, exp_t);
      chk("redirect", bif.RedirectPC_E, exp_t ? target : pce + 32'd4);
    end
    chk("mispredict", bif.Mispredict_E, exp_mis);
    @(posedge clk);
    #1;
    if (exp_branch) begin
      if (exp_t && mdl[pce[7:2]] != 2'd3) mdl[pce[7:2]] = mdl[pce[7:2]] + 2'd1;
      if (!exp_t && mdl[pce[7:2]] != 2'd0) mdl[pce[7:2]] = mdl[pce[7:2]] - 2'd1;
    end
    if (exp_mis) mcount = mcount + 32'd1;
    chk("mispredict_count", bif.MispredictCount, mcount);
  endtask

  task automatic idle_inputs();
    bif.ResolveValid_E = 1'b0; bif.ConditionalPCSrc_E = 3'd0; bif.PCE = '0; bif.PCF = '0;
    bif.PredictedTaken_E = 1'b0; bif.Zero = 1'b0; bif.Carry = 1'b0; bif.Negative = 1'b0;
    bif.oVerflow = 1'b0; bif.PCp4_E = '0; bif.BranchTarget_E = '0;
  endtask

  initial begin
    logic [31:0] a, b, d, pce, pcf;
    logic        z, c, n, v, et;
    logic [2:0]  code;

    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset state of all 64 entries and the counter.
    for (int i = 0; i < 64; i++) lookup(32'(i * 4));
    chk("reset_count", bif.MispredictCount, 32'd0);

    // BEQ mispredict at 0x40.
    step(1'b1, 3'd1, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
    lookup(32'h40);
    chk("beq_entry16", mdl[16], 2'b10);

    // Flag truth table for every condition code.
    for (int cd = 1; cd <= 6; cd++) begin
      for (int nv = 0; nv < 4; nv++) begin
        for (int cc = 0; cc < 2; cc++) begin
          z = 1'($urandom);
          n = nv[1]; v = nv[0]; c = cc[0];
          case (cd)
            1: et = z;
            2: et = !z;
            3: et = (n != v);
            4: et = (n == v);
            5: et = c;
            default: et = !c;
          endcase
          step(1'b1, 3'(cd), 32'h800 + 32'(cd * 64 + nv * 8 + cc * 4), 32'($urandom),
               1'($urandom), z, c, n, v, et, $urandom);
        end
      end
    end

    // Saturation at 0x10, starting from a clean table.
    reset = 1'b1; #2; reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++)
      step(1'b1, 3'd5, 32'h10, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
    chk("sat_high", mdl[4], 2'b11);
    lookup(32'h10);
    for (int k = 0; k < 5; k++)
      step(1'b1, 3'd6, 32'h10, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200);
    chk("sat_low", mdl[4], 2'b00);
    lookup(32'h10);

    // Same-index lookup and update, then alias.
    step(1'b1, 3'd2, 32'h20, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300);
    lookup(32'h20);
    lookup(32'h120);

    // Gating: NONE code and invalid resolve leave state untouched.
    step(1'b1, 3'd0, 32'h30, 32'h30, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h400);
    step(1'b0, 3'd1, 32'h30, 32'h30, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400);
    step(1'b0, 3'd7, 32'h30, 32'h30, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h400);
    lookup(32'h30);

    // Randomised resolves from real operand pairs.
    for (int k = 0; k < 300; k++) begin
      a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = {~a[31], b[30:0]};
      d = a - b;
      z = (a == b); c = (a < b); n = d[31];
      v = (a[31] != b[31]) && (d[31] != a[31]);
      code = 3'($urandom_range(0, 6));
      case (code)
        3'd1: et = (a == b);
        3'd2: et = (a != b);
        3'd3: et = ($signed(a) < $signed(b));
        3'd4: et = ($signed(a) >= $signed(b));
        3'd5: et = (a < b);
        3'd6: et = (a >= b);
        default: et = 1'b0;
      endcase
      pce = {22'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 2'b00};
      pcf = ($urandom_range(0, 1) == 0) ? pce : {$urandom} & 32'h3FC;
      step(1'($urandom_range(0, 4) != 0), code, pce, pcf, 1'($urandom),
           z, c, n, v, et, $urandom);
    end

    // Asynchronous reset between edges after three mispredicts.
    for (int k = 0; k < 3; k++)
      step(1'b1, 3'd1, 32'h34, 32'h34, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h500);
    chk("trained_entry13", mdl[13], 2'b11);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_count", bif.MispredictCount, 32'd0);
    lookup(32'h34);
    lookup(32'h40);
    // A resolve held across an edge while reset is high is dropped.
    bif.ResolveValid_E = 1'b1; bif.ConditionalPCSrc_E = 3'd1; bif.PCE = 32'h34;
    bif.Zero = 1'b1; bif.PredictedTaken_E = 1'b0; bif.PCF = 32'h34;
    @(posedge clk); #1;
    chk("reset_hold_count", bif.MispredictCount, 32'd0);
    chk("reset_hold_predict", bif.PredictTakenF, 1'b0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    @(posedge clk); #1;
    lookup(32'h34);
    step(1'b1, 3'd3, 32'h34, 32'h34, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h600);
    lookup(32'h34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
Parametrised successor to the execute-stage branch condition logic. Resolves all six RV32/64 conditional branches from ALU flags, detects mispredictions against a fetch-time prediction, and maintains a direct-mapped table of 2-bit saturating counters. The table is read in Fetch and updated at Execute resolve. Also keeps a running mispredict counter for performance monitoring.

Parameters:
XLEN, 32, datapath and PC width
ENTRIES, 64, number of prediction counters; power of two, at least 2
INDEX_LO, 2, lowest PC bit used for the table index; index = PC[INDEX_LO +: log2(ENTRIES)]
COUNTER_RESET, 2'b01, reset value of every counter (weakly not-taken)
CNT_W, 32, mispredict counter width

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
PCF  in  XLEN  fetch PC used for the lookup
PredictTakenF  out  1  MSB of the counter indexed by PCF
ResolveValid_E  in  1  Execute holds a valid, non-stalled, non-flushed instruction
ConditionalPCSrc_E  in  3  0=NONE, 1=BEQ, 2=BNE, 3=BLT, 4=BGE, 5=BLTU, 6=BGEU, 7=reserved
PCE  in  XLEN  PC of the Execute instruction, used for the update index
PredictedTaken_E  in  1  PredictTakenF carried down the pipeline with the instruction
Zero, Carry, Negative, oVerflow  in  1 each  ALU flags from rs1-rs2; Carry=1 means unsigned rs1<rs2
PCp4_E  in  XLEN  PCE+4
BranchTarget_E  in  XLEN  PCE+imm
Taken_E  out  1  resolved branch direction
Mispredict_E  out  1  flush/redirect request
RedirectPC_E  out  XLEN  correct next PC when Mispredict_E=1
MispredictCount  out  CNT_W  running count of mispredictions

Behaviour:
- Conditions: BEQ=Zero; BNE=~Zero; BLT=N^V; BGE=~(N^V); BLTU=Carry; BGEU=~Carry. Taken_E=0 for NONE and reserved.
- Branch_E = ResolveValid_E and code in 1..6. Code 7 is handled as NONE; a simulation assertion fires if code 7 appears with ResolveValid_E=1.
- Mispredict_E = Branch_E and (Taken_E != PredictedTaken_E). This is combinational, with zero-cycle latency to the hazard unit.
- RedirectPC_E = BranchTarget_E if Taken_E, otherwise PCp4_E. The value is don't-care when Mispredict_E=0, but is still driven deterministically.
- PredictTakenF is a combinational read of the table and is independent of the resolve inputs.
- Counter update:
  - On a clk edge with Branch_E=1, entry[idx(PCE)] saturating-increments if Taken_E, otherwise saturating-decrements.
  - Sequence: 00 -> 01 -> 10 -> 11, holding at 11 when incremented and at 00 when decremented.
  - No update when Branch_E=0.
- Same-cycle lookup and update of the same index: there is no bypass. PredictTakenF shows the pre-update value; the new value is visible from the next cycle.
- Aliasing: PCs with equal index bits share a counter. There are no tags.
- MispredictCount increments by 1 on each edge where Mispredict_E=1. It wraps modulo 2^CNT_W and does not saturate.
- Reset: asynchronous. When reset is asserted, every counter goes to COUNTER_RESET and MispredictCount goes to 0 immediately, without waiting for a clock edge. Combinational outputs follow their inputs during reset, but no state changes while reset=1. Deassertion mid-operation leaves the table cleanly at its reset value; a resolve presented in the same cycle as reset is dropped.
- Table storage is a flop array (no SRAM) so that the asynchronous reset is legal.

Test Plan:
- Reset, then lookup of PCF=0x0,0x4,...,0xFC -> PredictTakenF=0 for all 64 entries; MispredictCount=0.
- BEQ at PCE=0x40, Zero=1, PredictedTaken_E=0, BranchTarget_E=0x80 -> Taken_E=1, Mispredict_E=1, RedirectPC_E=0x80. Next cycle: entry 16 = 10, PCF=0x40 gives PredictTakenF=1, and MispredictCount=1.
- All six conditions with flag pairs (N,V) in {00,01,10,11} and Carry in {0,1} -> Taken_E matches the conditions table above. BLT with N=1,V=1 gives not taken. BLTU with Carry=1 gives taken.
- Counter saturation at PCE=0x10:
  - Taken five times -> entry 4 ends at 11 and holds.
  - Not taken five times -> ends at 00 and holds.
  - PredictTakenF flips only on the 01<->10 transitions.
- Same-index collision: PCF=PCE=0x20 with a taken update from 01 -> PredictTakenF=0 that cycle, 1 the next. An alias at PCF=0x120 (with ENTRIES=64) also reads 1.
- Gating and async reset:
  - ConditionalPCSrc_E=NONE, or ResolveValid_E=0, with mismatching flags -> Mispredict_E=0 and the table is unchanged.
  - Asserting reset between clock edges after 3 mispredicts -> MispredictCount=0 and the trained entries return to 01 immediately.
